instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0040_0000, SHALL be the PC loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, SHALL be the instr value whenever instr_valid=0.
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 reset  input  1  SHALL be synchronous and active-low (0 = reset, sampled on clk rising edge).
REQ-005 imem_req  output  1  instruction memory read request.
REQ-006 imem_addr  output  32  byte address of requested word.
REQ-007 imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 stall  input  1  downstream not ready; hold current instruction.
REQ-010 Branch  input  1  taken conditional branch from the control decoder.
REQ-011 PcUpdate  input  1  unconditional jump from the control decoder.
REQ-012 target_pc  input  32  redirect address from the datapath.
REQ-013 instr_valid  output  1  instr/pc hold a live instruction.
REQ-014 instr  output  32  instruction register.
REQ-015 opcode  output  7  instr[6:0]; Funct3 output 3 instr[14:12]; Funct7 output 7 instr[31:25].
REQ-016 pc  output  32  address of instr; pc_plus4 output 32 pc+4.

Function
REQ-017 States SHALL be IDLE, REQ, HOLD (plus TRAP, see Configuration).
REQ-018 IDLE SHALL last exactly one cycle after reset release, then go to REQ.
REQ-019 REQ: imem_req=1 and imem_addr=fetch_pc, both held stable until imem_ack.
REQ-020 REQ with imem_ack=1 SHALL capture imem_rdata into instr, set pc=fetch_pc, and enter HOLD next cycle with instr_valid=1.
REQ-021 REQ with imem_ack=0 SHALL stay in REQ (unbounded wait states).
REQ-022 imem_ack outside REQ SHALL be ignored.
REQ-023 HOLD with stall=1 SHALL keep instr, pc, and instr_valid unchanged.
REQ-024 HOLD with stall=0 SHALL set fetch_pc = (Branch|PcUpdate) ? target_pc : pc+4, clear instr_valid, and go to REQ.
REQ-025 Branch and PcUpdate SHALL be sampled only in HOLD with stall=0; when both are 1, target_pc is used.
REQ-026 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-027 Minimum throughput SHALL be one instruction per 2 cycles (REQ with ack in the same cycle, then HOLD).
REQ-028 instr SHALL equal NOP_INSTR whenever instr_valid=0; opcode, Funct3, and Funct7 SHALL be derived from instr.

Reset
REQ-029 Reset SHALL give: state=IDLE, fetch_pc=pc=RESET_PC, imem_req=0, instr_valid=0, instr=NOP_INSTR.
REQ-030 Reset asserted mid-REQ SHALL drop imem_req on the next edge and discard any ack that cycle.
REQ-031 Reset SHALL take priority over every other input.

Configuration
REQ-032 With FETCH_MISALIGN_TRAP_EN defined:
- Output port misalign (1 bit) SHALL exist, with reset value 0.
- A redirect with target_pc[1:0]!=0 SHALL enter TRAP with misalign=1, imem_req=0, instr_valid=0.
- TRAP SHALL be left only by reset.
REQ-033 Without FETCH_MISALIGN_TRAP_EN:
- The misalign port and TRAP state SHALL be absent.
- target_pc[1:0] SHALL be forced to 2'b00 on redirect.

Verification
REQ-034 Reset release, memory acks immediately -> first imem_req with imem_addr=32'h0040_0000 one cycle after IDLE; instr_valid the following cycle.
REQ-035 imem_ack delayed 3 cycles -> imem_addr stable for 4 REQ cycles; instr equals imem_rdata from the ack cycle.
REQ-036 HOLD with stall=1 for 5 cycles, then Branch=1, target_pc=32'h0040_0100 -> next imem_addr=32'h0040_0100.
REQ-037 pc=32'hFFFF_FFFC, no redirect, stall=0 -> next imem_addr=32'h0000_0000.
REQ-038 Reset asserted while REQ awaits ack, ack arrives same cycle -> instr_valid=0, pc=RESET_PC, instr=32'h0000_0013.
REQ-039 PcUpdate=1, target_pc=32'h0040_0102 -> with macro: misalign=1 and no further requests; without macro: imem_addr=32'h0040_0100.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch unit with one-entry instruction register.
// Latency: first request 1 cycle after reset release; >= 2 cycles per instruction (REQ+ack, then HOLD).
// Backpressure: unbounded memory wait states in REQ; stall=1 in HOLD freezes instr/pc/instr_valid.
//
// Ports:
//   clk, reset (synchronous, active-low)
//   imem_req/imem_addr out, imem_ack/imem_rdata in    : instruction memory handshake
//   stall, Branch, PcUpdate, target_pc in             : downstream backpressure and redirect
//   instr_valid, instr, opcode, Funct3, Funct7, pc, pc_plus4 out : fetched instruction
//   misalign out (only with FETCH_MISALIGN_TRAP_EN)   : sticky misaligned-redirect trap flag
// Optional feature: define FETCH_MISALIGN_TRAP_EN to trap on misaligned redirect targets;
// otherwise the low two target bits are cleared on redirect.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        Branch,
  input  logic        PcUpdate,
  input  logic [31:0] target_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [2:0]  Funct3,
  output logic [6:0]  Funct7,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    S_TRAP = 2'd3
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic        imem_req_q, imem_req_d;
  logic        redirect;
  logic [31:0] pc_inc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_q, misalign_d;
`endif

  assign redirect = Branch | PcUpdate;
  // 32-bit add wraps naturally modulo 2^32.
  assign pc_inc   = pc_q + 32'd4;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    imem_req_d    = imem_req_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_d    = misalign_q;
`endif
    case (state_q)
      S_IDLE: begin
        state_d    = S_REQ;
        imem_req_d = 1'b1;
      end
      S_REQ: begin
        // Request and address stay registered until the memory acknowledges.
        if (imem_ack) begin
          instr_d       = imem_rdata;
          pc_d          = fetch_pc_q;
          instr_valid_d = 1'b1;
          imem_req_d    = 1'b0;
          state_d       = S_HOLD;
        end
      end
      S_HOLD: begin
        // Redirect inputs only matter on the cycle the instruction is consumed.
        if (!stall) begin
          instr_valid_d = 1'b0;
          instr_d       = NOP_INSTR;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (redirect && (target_pc[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
            imem_req_d = 1'b0;
            state_d    = S_TRAP;
          end else begin
            fetch_pc_d = redirect ? target_pc : pc_inc;
            imem_req_d = 1'b1;
            state_d    = S_REQ;
          end
`else
          fetch_pc_d = redirect ? (target_pc & 32'hFFFF_FFFC) : pc_inc;
          imem_req_d = 1'b1;
          state_d    = S_REQ;
`endif
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      S_TRAP: begin
        // Sticky: only reset leaves this state.
        state_d = S_TRAP;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      fetch_pc_q    <= RESET_PC;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      imem_req_q    <= imem_req_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q    <= misalign_d;
`endif
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = fetch_pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[6:0];
  assign Funct3      = instr_q[14:12];
  assign Funct7      = instr_q[31:25];
  assign pc          = pc_q;
  assign pc_plus4    = pc_inc;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign    = misalign_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed vector table followed by randomized traffic against a reference model.
// Latency: n/a (bench).
// Backpressure: bench drives random ack delays and stalls.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        Branch;
  logic        PcUpdate;
  logic [31:0] target_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  Funct3;
  logic [6:0]  Funct7;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        mis_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .Branch     (Branch),
    .PcUpdate   (PcUpdate),
    .target_pc  (target_pc),
    .instr_valid(instr_valid),
    .instr      (instr),
    .opcode     (opcode),
    .Funct3     (Funct3),
    .Funct7     (Funct7),
    .pc         (pc),
    .pc_plus4   (pc_plus4)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misalign   (mis_out)
`endif
  );

`ifndef FETCH_MISALIGN_TRAP_EN
  assign mis_out = 1'b0;
`endif

  typedef struct {
    logic        rst_n;
    logic        ack;
    logic [31:0] rdata;
    logic        stl;
    logic        br;
    logic        pu;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_mis;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(logic r, logic a, logic [31:0] d, logic s, logic b, logic u,
                              logic [31:0] t, logic q, logic [31:0] ad, logic v,
                              logic [31:0] ins, logic [31:0] p, logic m);
    vec_t x;
    x.rst_n = r;  x.ack = a;  x.rdata = d;  x.stl = s;  x.br = b;  x.pu = u;  x.tgt = t;
    x.e_req = q;  x.e_addr = ad;  x.e_valid = v;  x.e_instr = ins;  x.e_pc = p;  x.e_mis = m;
    return x;
  endfunction

  task automatic chk(string name, int cyc, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Reference model: tracks "is a request outstanding", "is an instruction held",
  // and the addresses involved, straight from the fetch rules.
  logic        m_first;   // one idle cycle pending after reset
  logic        m_req;
  logic [31:0] m_addr;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic        m_trap;

  task automatic model_step();
    if (!reset) begin
      m_first = 1'b1; m_req = 1'b0; m_addr = RST_PC; m_valid = 1'b0;
      m_instr = NOP;  m_pc = RST_PC; m_trap = 1'b0;
    end else if (m_trap) begin
      // frozen until reset
    end else if (m_first) begin
      m_first = 1'b0;
      m_req   = 1'b1;
    end else if (m_req) begin
      if (imem_ack) begin
        m_req = 1'b0; m_valid = 1'b1; m_instr = imem_rdata; m_pc = m_addr;
      end
    end else if (m_valid && !stall) begin
      m_valid = 1'b0;
      m_instr = NOP;
`ifdef FETCH_MISALIGN_TRAP_EN
      if ((Branch || PcUpdate) && target_pc[1:0] != 2'b00) begin
        m_trap = 1'b1;
      end else begin
        m_req  = 1'b1;
        m_addr = (Branch || PcUpdate) ? target_pc : m_pc + 32'd4;
      end
`else
      m_req  = 1'b1;
      m_addr = (Branch || PcUpdate) ? {target_pc[31:2], 2'b00} : m_pc + 32'd4;
`endif
    end
  endtask

  initial begin
    logic [31:0] w;
    reset = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
    Branch = 1'b0; PcUpdate = 1'b0; target_pc = 32'h0;

    //              rst ack rdata          stl br pu target         req addr          vld instr          pc             mis
    tbl[0]  = mk(0, 0, 32'h0,          0, 0, 0, 32'h0,          0, RST_PC,        0, NOP,           RST_PC,        0);
    tbl[1]  = mk(1, 0, 32'h0,          0, 0, 0, 32'h0,          1, RST_PC,        0, NOP,           RST_PC,        0);
    tbl[2]  = mk(1, 0, 32'h0,          0, 0, 0, 32'h0,          1, RST_PC,        0, NOP,           RST_PC,        0);
    tbl[3]  = mk(1, 0, 32'h0,          0, 0, 0, 32'h0,          1, RST_PC,        0, NOP,           RST_PC,        0);
    tbl[4]  = mk(1, 0, 32'h0,          0, 0, 0, 32'h0,          1, RST_PC,        0, NOP,           RST_PC,        0);
    tbl[5]  = mk(1, 1, 32'hAABB_CC13,  0, 0, 0, 32'h0,          0, RST_PC,        1, 32'hAABB_CC13, RST_PC,        0);
    tbl[6]  = mk(1, 0, 32'h0,          1, 1, 0, 32'h0040_0100, 0, RST_PC,        1, 32'hAABB_CC13, RST_PC,        0);
    tbl[7]  = mk(1, 1, 32'hDEAD_BEEF,  1, 0, 0, 32'h0,          0, RST_PC,        1, 32'hAABB_CC13, RST_PC,        0);
    tbl[8]  = mk(1, 0, 32'h0,          1, 0, 1, 32'h1234_0000, 0, RST_PC,        1, 32'hAABB_CC13, RST_PC,        0);
    tbl[9]  = mk(1, 0, 32'h0,          1, 0, 0, 32'h0,          0, RST_PC,        1, 32'hAABB_CC13, RST_PC,        0);
    tbl[10] = mk(1, 0, 32'h0,          1, 0, 0, 32'h0,          0, RST_PC,        1, 32'hAABB_CC13, RST_PC,        0);
    tbl[11] = mk(1, 0, 32'h0,          0, 1, 0, 32'h0040_0100, 1, 32'h0040_0100, 0, NOP,           RST_PC,        0);
    tbl[12] = mk(1, 1, 32'h1234_5678,  0, 1, 0, 32'h0000_0800, 0, 32'h0040_0100, 1, 32'h1234_5678, 32'h0040_0100, 0);
    tbl[13] = mk(1, 0, 32'h0,          0, 0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, NOP,           32'h0040_0100, 0);
    tbl[14] = mk(1, 1, 32'h0000_0093,  0, 0, 0, 32'h0,          0, 32'hFFFF_FFFC, 1, 32'h0000_0093, 32'hFFFF_FFFC, 0);
    tbl[15] = mk(1, 0, 32'h0,          0, 0, 0, 32'h0,          1, 32'h0000_0000, 0, NOP,           32'hFFFF_FFFC, 0);
    tbl[16] = mk(1, 0, 32'h0,          1, 0, 0, 32'h0,          1, 32'h0000_0000, 0, NOP,           32'hFFFF_FFFC, 0);
    tbl[17] = mk(1, 1, 32'h1111_1111,  0, 0, 0, 32'h0,          0, 32'h0000_0000, 1, 32'h1111_1111, 32'h0000_0000, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
    tbl[18] = mk(1, 0, 32'h0,          0, 0, 1, 32'h0040_0102, 0, 32'h0000_0000, 0, NOP,           32'h0000_0000, 1);
    tbl[19] = mk(1, 1, 32'h2222_2222,  0, 0, 0, 32'h0,          0, 32'h0000_0000, 0, NOP,           32'h0000_0000, 1);
    tbl[20] = mk(1, 0, 32'h0,          0, 0, 0, 32'h0,          0, 32'h0000_0000, 0, NOP,           32'h0000_0000, 1);
`else
    tbl[18] = mk(1, 0, 32'h0,          0, 0, 1, 32'h0040_0102, 1, 32'h0040_0100, 0, NOP,           32'h0000_0000, 0);
    tbl[19] = mk(1, 1, 32'h2222_2222,  0, 0, 0, 32'h0,          0, 32'h0040_0100, 1, 32'h2222_2222, 32'h0040_0100, 0);
    tbl[20] = mk(1, 0, 32'h0,          0, 0, 0, 32'h0,          1, 32'h0040_0104, 0, NOP,           32'h0040_0100, 0);
`endif
    tbl[21] = mk(0, 1, 32'h3333_3333,  0, 1, 1, 32'h0000_1000, 0, RST_PC,        0, NOP,           RST_PC,        0);
    tbl[22] = mk(1, 0, 32'h0,          0, 0, 0, 32'h0,          1, RST_PC,        0, NOP,           RST_PC,        0);

    for (int i = 0; i < 23; i++) begin
      reset = tbl[i].rst_n; imem_ack = tbl[i].ack; imem_rdata = tbl[i].rdata;
      stall = tbl[i].stl;   Branch = tbl[i].br;    PcUpdate = tbl[i].pu;
      target_pc = tbl[i].tgt;
      @(posedge clk);
      #1;
      chk("vec_req",      i, {31'b0, imem_req},    {31'b0, tbl[i].e_req});
      chk("vec_addr",     i, imem_addr,            tbl[i].e_addr);
      chk("vec_valid",    i, {31'b0, instr_valid}, {31'b0, tbl[i].e_valid});
      chk("vec_instr",    i, instr,                tbl[i].e_instr);
      chk("vec_pc",       i, pc,                   tbl[i].e_pc);
      chk("vec_pc_plus4", i, pc_plus4,             tbl[i].e_pc + 32'd4);
      chk("vec_misalign", i, {31'b0, mis_out},     {31'b0, tbl[i].e_mis});
    end

    // Randomized traffic; starts from a reset so the model and DUT agree.
    for (int c = 0; c < 3000; c++) begin
      reset      = (c < 2) ? 1'b0 : ($urandom_range(0, 199) != 0);
      imem_ack   = ($urandom_range(0, 9) < 6);
      imem_rdata = $urandom;
      stall      = ($urandom_range(0, 9) < 3);
      Branch     = ($urandom_range(0, 9) < 2);
      PcUpdate   = ($urandom_range(0, 9) < 2);
      w          = $urandom;
      // Mostly aligned targets, occasionally misaligned, sometimes near the top of memory.
      if ($urandom_range(0, 7) != 0) w[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) w[31:4] = 28'hFFF_FFFF;
      target_pc  = w;
      model_step();
      @(posedge clk);
      #1;
      chk("rnd_req",      c, {31'b0, imem_req},    {31'b0, m_req});
      chk("rnd_addr",     c, imem_addr,            m_addr);
      chk("rnd_valid",    c, {31'b0, instr_valid}, {31'b0, m_valid});
      chk("rnd_instr",    c, instr,                m_instr);
      chk("rnd_pc",       c, pc,                   m_pc);
      chk("rnd_pc_plus4", c, pc_plus4,             m_pc + 32'd4);
      chk("rnd_opcode",   c, {25'b0, opcode},      {25'b0, m_instr[6:0]});
      chk("rnd_funct3",   c, {29'b0, Funct3},      {29'b0, m_instr[14:12]});
      chk("rnd_funct7",   c, {25'b0, Funct7},      {25'b0, m_instr[31:25]});
      chk("rnd_misalign", c, {31'b0, mis_out},     {31'b0, m_trap});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
